// File: rtl/parse_act_cfg.sv
// Configuration writer for the parser's parse-action RAM: assembles 260-bit entries from
// 3-beat AXI-Stream control packets and commits them outside the parser's extraction window.
module parse_act_cfg #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned PARSE_ACT_RAM_WIDTH  = 260,
  parameter int unsigned RAM_ADDR_WIDTH       = 4,
  parameter logic [7:0]  MOD_ID               = 8'h00
) (
  input  logic                             axis_clk,
  input  logic                             aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                             s_axis_tvalid,
  input  logic                             s_axis_tlast,
  output logic                             s_axis_tready,
  input  logic                             parser_busy,
  output logic                             cfg_wr_en,
  output logic                             cfg_wr_we,
  output logic [RAM_ADDR_WIDTH-1:0]        cfg_wr_addr,
  output logic [PARSE_ACT_RAM_WIDTH-1:0]   cfg_wr_data,
  output logic                             cfg_done,
  output logic [15:0]                      cfg_wr_cnt,
  output logic [15:0]                      cfg_err_cnt
);

  localparam int unsigned HiW     = PARSE_ACT_RAM_WIDTH - C_S_AXIS_DATA_WIDTH;
  localparam logic [7:0]  OpWrite = 8'h01;

  typedef enum logic [2:0] {StHdr, StDataLo, StDataHi, StDrop, StCommit} state_e;

  state_e                           state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0]        idx_q, idx_d;
  logic [PARSE_ACT_RAM_WIDTH-1:0]   entry_q, entry_d;
  logic                             wr_en_q, wr_en_d;
  logic [RAM_ADDR_WIDTH-1:0]        wr_addr_q, wr_addr_d;
  logic [PARSE_ACT_RAM_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [15:0]                      wr_cnt_q, wr_cnt_d;
  logic [15:0]                      err_cnt_q, err_cnt_d;
  logic                             err_inc;
  logic                             beat;
  logic [7:0]                       hdr_mod, hdr_op;

  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tuser, s_axis_tkeep};

  assign s_axis_tready = aresetn & (state_q != StCommit);
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign hdr_mod       = s_axis_tdata[7:0];
  assign hdr_op        = s_axis_tdata[15:8];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    entry_d   = entry_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_cnt_d  = wr_cnt_q;
    err_inc   = 1'b0;
    unique case (state_q)
      StHdr: begin
        if (beat) begin
          // Packets for other modules are skipped silently; they are not errors here.
          if (hdr_mod != MOD_ID) begin
            state_d = s_axis_tlast ? StHdr : StDrop;
          end else if (hdr_op != OpWrite) begin
            err_inc = 1'b1;
            state_d = s_axis_tlast ? StHdr : StDrop;
          end else if (s_axis_tlast) begin
            err_inc = 1'b1;
          end else begin
            idx_d   = s_axis_tdata[16 +: RAM_ADDR_WIDTH];
            state_d = StDataLo;
          end
        end
      end
      StDataLo: begin
        if (beat) begin
          entry_d[C_S_AXIS_DATA_WIDTH-1:0] = s_axis_tdata;
          if (s_axis_tlast) begin
            err_inc = 1'b1;
            state_d = StHdr;
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (beat) begin
          entry_d[PARSE_ACT_RAM_WIDTH-1:C_S_AXIS_DATA_WIDTH] = s_axis_tdata[HiW-1:0];
          if (s_axis_tlast) begin
            state_d = StCommit;
          end else begin
            err_inc = 1'b1;
            state_d = StDrop;
          end
        end
      end
      StDrop: begin
        if (beat && s_axis_tlast) state_d = StHdr;
      end
      StCommit: begin
        if (!parser_busy) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = entry_q;
          wr_cnt_d  = wr_cnt_q + 16'd1;
          state_d   = StHdr;
        end
      end
      default: state_d = StHdr;
    endcase
    err_cnt_d = (err_inc && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StHdr;
      idx_q     <= '0;
      entry_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      entry_q   <= entry_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign cfg_wr_en   = wr_en_q;
  assign cfg_wr_we   = wr_en_q;
  assign cfg_done    = wr_en_q;
  assign cfg_wr_addr = wr_addr_q;
  assign cfg_wr_data = wr_data_q;
  assign cfg_wr_cnt  = wr_cnt_q;
  assign cfg_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_parse_act_cfg.sv
// Bench for parse_act_cfg: expected RAM writes are queued as packets are driven and matched
// against writes captured from the RAM port.
module tb_parse_act_cfg;

  logic         axis_clk = 1'b0;
  logic         aresetn;
  logic [255:0] s_axis_tdata;
  logic [127:0] s_axis_tuser;
  logic [31:0]  s_axis_tkeep;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic         parser_busy;
  logic         cfg_wr_en;
  logic         cfg_wr_we;
  logic [3:0]   cfg_wr_addr;
  logic [259:0] cfg_wr_data;
  logic         cfg_done;
  logic [15:0]  cfg_wr_cnt;
  logic [15:0]  cfg_err_cnt;

  parse_act_cfg dut (
    .axis_clk      (axis_clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .parser_busy   (parser_busy),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_wr_we     (cfg_wr_we),
    .cfg_wr_addr   (cfg_wr_addr),
    .cfg_wr_data   (cfg_wr_data),
    .cfg_done      (cfg_done),
    .cfg_wr_cnt    (cfg_wr_cnt),
    .cfg_err_cnt   (cfg_err_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  int cyc = 0;
  always @(posedge axis_clk) cyc <= cyc + 1;

  // Write monitor: captures every cycle the RAM port is enabled.
  logic [3:0]   obs_addr [64];
  logic [259:0] obs_data [64];
  int           obs_cyc  [64];
  logic         obs_we   [64];
  logic         obs_done [64];
  int           obs_n = 0;
  int           stray = 0;
  always @(negedge axis_clk) begin
    if (cfg_wr_en && obs_n < 64) begin
      obs_addr[obs_n] <= cfg_wr_addr;
      obs_data[obs_n] <= cfg_wr_data;
      obs_cyc[obs_n]  <= cyc;
      obs_we[obs_n]   <= cfg_wr_we;
      obs_done[obs_n] <= cfg_done;
      obs_n           <= obs_n + 1;
    end
    if ((cfg_wr_we || cfg_done) && !cfg_wr_en) stray <= stray + 1;
  end

  typedef struct {
    logic [3:0]   addr;
    logic [259:0] data;
    int           cyc;
  } exp_t;
  exp_t exp_q[$];
  int   rd = 0;

  typedef struct {
    logic [7:0] mod;
    logic [7:0] op;
    logic [3:0] idx;
    int         nbeats;
    bit         exp_wr;
    int         exp_err_inc;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [259:0] got, input logic [259:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  task automatic send_beat(input logic [255:0] d, input logic last);
    int t = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    while (!s_axis_tready && t < 60) begin
      @(negedge axis_clk);
      t++;
    end
    if (!s_axis_tready) begin
      n_total++;
      $display("FAIL accept_timeout: tready %0b after %0d cycles, expected 1", s_axis_tready, t);
    end
    @(posedge axis_clk);
    #1;
  endtask

  // Sends one packet; tvalid is left high so callers can stream packets back to back.
  task automatic send_pkt(input logic [7:0] mod, input logic [7:0] op, input logic [3:0] idx,
                          input logic [255:0] lo, input logic [3:0] hi, input int nbeats,
                          output int tl_cyc);
    logic [255:0] d;
    for (int b = 0; b < nbeats; b++) begin
      d = rand256();
      if (b == 0) begin
        d[7:0]   = mod;
        d[15:8]  = op;
        d[19:16] = idx;
      end else if (b == 1) begin
        d = lo;
      end else if (b == 2) begin
        d[3:0] = hi;
      end
      send_beat(d, b == nbeats - 1);
    end
    tl_cyc = cyc;
  endtask

  task automatic drain(input string name);
    exp_t e;
    repeat (6) @(posedge axis_clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd >= obs_n) begin
        n_total++;
        $display("FAIL %s_missing_write: got none, expected addr %0d", name, e.addr);
      end else begin
        chk({name, "_addr"}, obs_addr[rd], e.addr);
        chk({name, "_data"}, obs_data[rd], e.data);
        chk({name, "_cycle"}, obs_cyc[rd], e.cyc);
        chk({name, "_we_done"}, {obs_we[rd], obs_done[rd]}, 2'b11);
        rd++;
      end
    end
    chk({name, "_no_extra_write"}, obs_n - rd, 0);
    rd = obs_n;
  endtask

  initial begin
    vec_t         vt[5];
    int           tl, tl_first, err_exp;
    logic [255:0] lo;
    logic [3:0]   hi;

    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    s_axis_tkeep  = '1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    parser_busy   = 1'b0;
    repeat (3) @(posedge axis_clk);
    #1;
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_wr_en", cfg_wr_en, 0);
    chk("rst_wr_we", cfg_wr_we, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_addr", cfg_wr_addr, 0);
    chk("rst_data", cfg_wr_data, 0);
    chk("rst_wr_cnt", cfg_wr_cnt, 0);
    chk("rst_err_cnt", cfg_err_cnt, 0);
    aresetn = 1'b1;
    @(posedge axis_clk);
    #1;
    chk("tready_after_rst", s_axis_tready, 1);

    // Well-formed write, parser idle.
    lo = {8{32'hA5A5_0000}};
    send_pkt(8'h00, 8'h01, 4'd5, lo, 4'hC, 3, tl);
    s_axis_tvalid = 1'b0;
    exp_q.push_back('{addr: 4'd5, data: {4'hC, lo}, cyc: tl + 1});
    chk("t1_tready_low", s_axis_tready, 0);
    @(posedge axis_clk);
    #1;
    chk("t1_tready_back", s_axis_tready, 1);
    chk("t1_pulse", cfg_wr_en, 1);
    drain("t1");
    chk("t1_wr_cnt", cfg_wr_cnt, 1);

    // Busy stall: write withheld for 7 cycles.
    lo = rand256();
    hi = 4'(($urandom));
    parser_busy = 1'b1;
    send_pkt(8'h00, 8'h01, 4'd9, lo, hi, 3, tl);
    s_axis_tvalid = 1'b0;
    exp_q.push_back('{addr: 4'd9, data: {hi, lo}, cyc: tl + 8});
    for (int i = 0; i < 7; i++) begin
      @(posedge axis_clk);
      #1;
      chk("stall_no_write_tready_low", {cfg_wr_en, s_axis_tready}, 2'b00);
    end
    parser_busy = 1'b0;
    drain("stall");
    chk("stall_wr_cnt", cfg_wr_cnt, 2);

    // Foreign module, malformed packets, then a good write to index 15.
    vt[0] = '{mod: 8'h03, op: 8'h01, idx: 4'd1, nbeats: 5, exp_wr: 0, exp_err_inc: 0};
    vt[1] = '{mod: 8'h00, op: 8'h01, idx: 4'd2, nbeats: 2, exp_wr: 0, exp_err_inc: 1};
    vt[2] = '{mod: 8'h00, op: 8'h01, idx: 4'd3, nbeats: 4, exp_wr: 0, exp_err_inc: 1};
    vt[3] = '{mod: 8'h00, op: 8'h02, idx: 4'd4, nbeats: 3, exp_wr: 0, exp_err_inc: 1};
    vt[4] = '{mod: 8'h00, op: 8'h01, idx: 4'd15, nbeats: 3, exp_wr: 1, exp_err_inc: 0};
    err_exp = 0;
    for (int v = 0; v < 5; v++) begin
      lo = rand256();
      hi = 4'($urandom);
      send_pkt(vt[v].mod, vt[v].op, vt[v].idx, lo, hi, vt[v].nbeats, tl);
      s_axis_tvalid = 1'b0;
      if (vt[v].exp_wr) exp_q.push_back('{addr: vt[v].idx, data: {hi, lo}, cyc: tl + 1});
      err_exp += vt[v].exp_err_inc;
      drain($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_err_cnt", v), cfg_err_cnt, 16'(err_exp));
    end
    chk("vec_wr_cnt", cfg_wr_cnt, 3);

    // Back-to-back stream to every index.
    tl_first = 0;
    for (int i = 0; i < 16; i++) begin
      lo = rand256();
      hi = 4'($urandom);
      send_pkt(8'h00, 8'h01, 4'(i), lo, hi, 3, tl);
      if (i == 0) tl_first = tl;
      exp_q.push_back('{addr: 4'(i), data: {hi, lo}, cyc: tl + 1});
    end
    s_axis_tvalid = 1'b0;
    chk("b2b_spacing", tl - tl_first, 60);
    drain("b2b");
    chk("b2b_wr_cnt", cfg_wr_cnt, 19);

    // Reset while a commit is held off by the parser.
    parser_busy = 1'b1;
    send_pkt(8'h00, 8'h01, 4'd7, rand256(), 4'hA, 3, tl);
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge axis_clk);
    #1;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_tready", s_axis_tready, 0);
    chk("mid_rst_outputs", {cfg_wr_en, cfg_wr_we, cfg_done, cfg_wr_addr, cfg_wr_data}, 0);
    chk("mid_rst_counters", {cfg_wr_cnt, cfg_err_cnt}, 0);
    repeat (2) @(posedge axis_clk);
    #1;
    aresetn = 1'b1;
    parser_busy = 1'b0;
    drain("rst_discard");
    lo = rand256();
    send_pkt(8'h00, 8'h01, 4'd11, lo, 4'h3, 3, tl);
    s_axis_tvalid = 1'b0;
    exp_q.push_back('{addr: 4'd11, data: {4'h3, lo}, cyc: tl + 1});
    drain("post_rst");
    chk("post_rst_wr_cnt", cfg_wr_cnt, 1);
    chk("post_rst_err_cnt", cfg_err_cnt, 0);
    chk("strobe_alignment", stray, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
